// File: rtl/irq_pending_ctrl_if.sv
// Signal bundle between the interrupt front end and its controller (CPU side).
// ack and eoi are single-cycle pulses with no backpressure: a pulse is consumed on the edge it is sampled, legal or not.
interface irq_pending_ctrl_if;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       ack;
    logic [1:0] ack_id;
    logic       eoi;
    logic [1:0] eoi_id;
    logic [3:0] interrupts;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       in_service;
    logic [1:0] in_service_id;
    logic       spurious;
    logic [1:0] dbg_state;

    modport master (
        output irq_in, mask_we, mask_wdata, ack, ack_id, eoi, eoi_id,
        input  interrupts, pending, mask, in_service, in_service_id, spurious, dbg_state
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, ack, ack_id, eoi, eoi_id,
        output interrupts, pending, mask, in_service, in_service_id, spurious, dbg_state
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: synchronizes four IRQ lines, latches rising edges as pending
// bits, masks them and tracks ack/EOI so only one source is in service at a time.
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    irq_pending_ctrl_if.slave  io_irq
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_SERVICE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_sync_prev;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic [1:0] r_in_service_id;
    logic       r_spurious;

    logic [3:0] w_edge;
    logic [3:0] w_vis;
    logic [3:0] w_clr;
    logic       w_ack_ok;
    logic       w_eoi_ok;

    assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_vis    = r_pending & ~r_mask;
    assign w_ack_ok = io_irq.ack && (r_state == ST_WAIT_ACK) && w_vis[io_irq.ack_id];
    assign w_eoi_ok = io_irq.eoi && (r_state == ST_SERVICE) && (io_irq.eoi_id == r_in_service_id);
    assign w_clr    = w_ack_ok ? (4'b0001 << io_irq.ack_id) : 4'b0000;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_sync_prev <= '0;
        end else begin
            r_sync[0] <= io_irq.irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Edge set is ORed in after the clear so a same-cycle edge survives the ack.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending       <= 4'b0000;
            r_mask          <= 4'b1111;
            r_in_service_id <= 2'd0;
            r_spurious      <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (io_irq.mask_we) r_mask <= io_irq.mask_wdata;
            if (w_ack_ok) r_in_service_id <= io_irq.ack_id;
            if ((io_irq.ack && !w_ack_ok) || (io_irq.eoi && !w_eoi_ok)) r_spurious <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_vis != 4'b0000) w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (w_ack_ok)                  w_next_state = ST_SERVICE;
                else if (w_vis == 4'b0000)     w_next_state = ST_IDLE;
            end
            ST_SERVICE: begin
                if (w_eoi_ok) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign io_irq.interrupts    = (r_state == ST_SERVICE) ? 4'b0000 : w_vis;
    assign io_irq.pending       = r_pending;
    assign io_irq.mask          = r_mask;
    assign io_irq.in_service    = (r_state == ST_SERVICE);
    assign io_irq.in_service_id = r_in_service_id;
    assign io_irq.spurious      = r_spurious;
    assign io_irq.dbg_state     = r_state;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: latency, masking, ack/EOI flow, spurious
// events, set/clear collision and reset in service.
module tb_irq_pending_ctrl;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_errors;

    irq_pending_ctrl_if u_if ();

    irq_pending_ctrl #(.SYNC_STAGES(2)) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .io_irq  (u_if)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_mask(input logic [3:0] v);
        u_if.mask_we    = 1'b1;
        u_if.mask_wdata = v;
        tick();
        u_if.mask_we    = 1'b0;
    endtask

    task automatic do_ack(input logic [1:0] id);
        u_if.ack    = 1'b1;
        u_if.ack_id = id;
        tick();
        u_if.ack    = 1'b0;
    endtask

    task automatic do_eoi(input logic [1:0] id);
        u_if.eoi    = 1'b1;
        u_if.eoi_id = id;
        tick();
        u_if.eoi    = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        i_rst_n         = 1'b0;
        u_if.irq_in     = 4'b0000;
        u_if.mask_we    = 1'b0;
        u_if.mask_wdata = 4'b0000;
        u_if.ack        = 1'b0;
        u_if.ack_id     = 2'd0;
        u_if.eoi        = 1'b0;
        u_if.eoi_id     = 2'd0;
        tick();
        tick();
        i_rst_n = 1'b1;

        // reset values
        check_eq("rst_mask",       {4'h0, u_if.mask},          8'h0f);
        check_eq("rst_interrupts", {4'h0, u_if.interrupts},    8'h00);
        check_eq("rst_pending",    {4'h0, u_if.pending},       8'h00);
        check_eq("rst_in_service", {7'h0, u_if.in_service},    8'h00);
        check_eq("rst_spurious",   {7'h0, u_if.spurious},      8'h00);
        check_eq("rst_state",      {6'h0, u_if.dbg_state},     {6'h0, S_IDLE});

        // 1: mask open, irq 2 latency, ack, eoi
        write_mask(4'b0000);
        check_eq("t1_mask", {4'h0, u_if.mask}, 8'h00);
        u_if.irq_in = 4'b0100;
        tick();
        tick();
        check_eq("t1_pend_early", {4'h0, u_if.pending}, 8'h00);
        tick();
        check_eq("t1_pend",  {4'h0, u_if.pending},    8'h04);
        check_eq("t1_int",   {4'h0, u_if.interrupts}, 8'h04);
        check_eq("t1_idle",  {6'h0, u_if.dbg_state},  {6'h0, S_IDLE});
        tick();
        check_eq("t1_wait",  {6'h0, u_if.dbg_state},  {6'h0, S_WAIT});
        do_ack(2'd2);
        check_eq("t1_insvc",    {7'h0, u_if.in_service},    8'h01);
        check_eq("t1_insvc_id", {6'h0, u_if.in_service_id}, 8'h02);
        check_eq("t1_int_svc",  {4'h0, u_if.interrupts},    8'h00);
        check_eq("t1_pend_clr", {4'h0, u_if.pending},       8'h00);
        do_eoi(2'd2);
        check_eq("t1_eoi_idle", {6'h0, u_if.dbg_state},     {6'h0, S_IDLE});
        check_eq("t1_eoi_insv", {7'h0, u_if.in_service},    8'h00);
        tick();
        tick();
        check_eq("t1_no_retrig", {4'h0, u_if.pending},      8'h00);
        check_eq("t1_spur0",     {7'h0, u_if.spurious},     8'h00);
        u_if.irq_in = 4'b0000;
        tick();
        tick();

        // 2: two sources pass through, lower id acked first
        u_if.irq_in = 4'b1010;
        tick();
        tick();
        tick();
        check_eq("t2_int", {4'h0, u_if.interrupts}, 8'h0a);
        tick();
        do_ack(2'd1);
        check_eq("t2_pend", {4'h0, u_if.pending}, 8'h08);
        check_eq("t2_id",   {6'h0, u_if.in_service_id}, 8'h01);
        do_eoi(2'd1);
        check_eq("t2_int_after_eoi", {4'h0, u_if.interrupts}, 8'h08);
        check_eq("t2_idle",          {6'h0, u_if.dbg_state},  {6'h0, S_IDLE});
        tick();
        check_eq("t2_wait", {6'h0, u_if.dbg_state}, {6'h0, S_WAIT});
        do_ack(2'd3);
        do_eoi(2'd3);
        u_if.irq_in = 4'b0000;
        tick();
        tick();

        // 3: masked edge still latches
        write_mask(4'b0001);
        u_if.irq_in = 4'b0001;
        tick();
        u_if.irq_in = 4'b0000;
        tick();
        tick();
        check_eq("t3_pend", {4'h0, u_if.pending},    8'h01);
        check_eq("t3_int",  {4'h0, u_if.interrupts}, 8'h00);
        tick();
        check_eq("t3_idle", {6'h0, u_if.dbg_state},  {6'h0, S_IDLE});
        write_mask(4'b0000);
        check_eq("t3_int_unmask", {4'h0, u_if.interrupts}, 8'h01);
        tick();
        do_ack(2'd0);
        do_eoi(2'd0);
        check_eq("t3_done", {6'h0, u_if.dbg_state}, {6'h0, S_IDLE});

        // 4: spurious ack and mismatched eoi
        do_ack(2'd3);
        check_eq("t4_spur",  {7'h0, u_if.spurious},  8'h01);
        check_eq("t4_idle",  {6'h0, u_if.dbg_state}, {6'h0, S_IDLE});
        check_eq("t4_pend",  {4'h0, u_if.pending},   8'h00);
        u_if.irq_in = 4'b0010;
        tick();
        tick();
        tick();
        tick();
        do_ack(2'd1);
        check_eq("t4_svc", {6'h0, u_if.dbg_state}, {6'h0, S_SERVICE});
        do_eoi(2'd2);
        check_eq("t4_stay_svc", {6'h0, u_if.dbg_state}, {6'h0, S_SERVICE});
        check_eq("t4_spur_sticky", {7'h0, u_if.spurious}, 8'h01);
        do_eoi(2'd1);
        check_eq("t4_idle2", {6'h0, u_if.dbg_state}, {6'h0, S_IDLE});
        u_if.irq_in = 4'b0000;
        tick();
        tick();

        // 5: fresh edge on bit 0 lands on the same edge as ack 0
        u_if.irq_in = 4'b0001;
        tick();
        u_if.irq_in = 4'b0000;
        tick();
        tick();
        tick();
        check_eq("t5_wait", {6'h0, u_if.dbg_state}, {6'h0, S_WAIT});
        u_if.irq_in = 4'b0001;
        tick();
        u_if.irq_in = 4'b0000;
        tick();
        do_ack(2'd0);
        check_eq("t5_pend_set_wins", {4'h0, u_if.pending},       8'h01);
        check_eq("t5_insvc_id",      {6'h0, u_if.in_service_id}, 8'h00);
        check_eq("t5_insvc",         {7'h0, u_if.in_service},    8'h01);
        do_eoi(2'd0);
        check_eq("t5_int_after_eoi", {4'h0, u_if.interrupts},    8'h01);
        tick();
        check_eq("t5_rewait", {6'h0, u_if.dbg_state}, {6'h0, S_WAIT});

        // 6: reset while in service
        do_ack(2'd0);
        u_if.irq_in = 4'b0110;
        tick();
        tick();
        tick();
        check_eq("t6_pend_svc", {4'h0, u_if.pending},    8'h06);
        check_eq("t6_int_svc",  {4'h0, u_if.interrupts}, 8'h00);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check_eq("t6_state",   {6'h0, u_if.dbg_state},     {6'h0, S_IDLE});
        check_eq("t6_pend",    {4'h0, u_if.pending},       8'h00);
        check_eq("t6_mask",    {4'h0, u_if.mask},          8'h0f);
        check_eq("t6_int",     {4'h0, u_if.interrupts},    8'h00);
        check_eq("t6_insvc",   {7'h0, u_if.in_service},    8'h00);
        check_eq("t6_insvcid", {6'h0, u_if.in_service_id}, 8'h00);
        check_eq("t6_spur",    {7'h0, u_if.spurious},      8'h00);
        tick();
        tick();
        tick();
        check_eq("t6_fresh_edge", {4'h0, u_if.pending},    8'h06);
        check_eq("t6_masked_int", {4'h0, u_if.interrupts}, 8'h00);
        check_eq("t6_idle_again", {6'h0, u_if.dbg_state},  {6'h0, S_IDLE});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
